data_island_packet_assembler: RTL and testbench

- Downstream consumer of the InfoFrame and packet generators' {header[23:0], sub[3:0][55:0]} output.
- Serialises one HDMI data-island packet over 32 pixel clocks.
- Appends the BCH ECC parity bytes to the header and to each subpacket, computed serially while the data streams out.
- Emits a 9-bit slot word per clock for the TERC4 channel encoders: channel 0 bit 2 carries the header bit, channels 1 and 2 carry the subpacket bits.

---
 rtl/data_island_packet_assembler_if.sv | 21 ++
 rtl/data_island_packet_assembler.sv | 140 ++++++++++++++
 tb/tb_data_island_packet_assembler.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_island_packet_assembler_if.sv
// Packet payload in, 9-bit TERC4 slot word out, between the packet generators,
// the data-island assembler and the channel encoders.
interface data_island_packet_assembler_if;
  logic             enable;
  logic [23:0]      header;
  logic [3:0][55:0] sub;
  logic [8:0]       packet_data;
  logic [4:0]       slot;
  logic             packet_start;
  logic             packet_end;

  modport master (
    output enable, header, sub,
    input  packet_data, slot, packet_start, packet_end
  );

  modport slave (
    input  enable, header, sub,
    output packet_data, slot, packet_start, packet_end
  );
endinterface

// File: rtl/data_island_packet_assembler.sv
// Serialises one HDMI data-island packet over 32 slots, appending BCH parity
// to the header and to each of the four subpackets as the bits stream out.
module data_island_packet_assembler (
  input  logic                          clk,
  input  logic                          reset_n,
  data_island_packet_assembler_if.slave bus
);

  localparam int unsigned HDR_W = 24;
  localparam int unsigned SUB_W = 56;
  localparam int unsigned NSUB  = 4;
  localparam int unsigned ECC_W = 8;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned PD_W  = 9;

  localparam logic [CNT_W-1:0] LAST_SLOT    = CNT_W'(31);
  localparam logic [CNT_W-1:0] HDR_ECC_SLOT = CNT_W'(24);
  localparam logic [CNT_W-1:0] SUB_ECC_SLOT = CNT_W'(28);
  localparam logic [ECC_W-1:0] BCH_POLY     = ECC_W'(8'h83);

  // One LSB-first step of the x^8+x^7+x^6+1 parity shift register.
  function automatic logic [ECC_W-1:0] nx(input logic [ECC_W-1:0] e, input logic b);
    return {1'b0, e[ECC_W-1:1]} ^ ({ECC_W{e[0] ^ b}} & BCH_POLY);
  endfunction

  logic [CNT_W-1:0]            r_cnt;
  logic [PD_W-1:0]             r_packet_data;
  logic [CNT_W-1:0]            r_slot;
  logic                        r_packet_start;
  logic                        r_packet_end;
  logic [ECC_W-1:0]            r_ecc_h;
  logic [NSUB-1:0][ECC_W-1:0]  r_ecc_s;
  logic [HDR_W-1:0]            r_shadow_h;
  logic [NSUB-1:0][SUB_W-1:0]  r_shadow_s;

  logic [CNT_W-1:0]            w_cnt_nxt;
  logic [PD_W-1:0]             w_packet_data_nxt;
  logic [CNT_W-1:0]            w_slot_nxt;
  logic                        w_packet_start_nxt;
  logic                        w_packet_end_nxt;
  logic [ECC_W-1:0]            w_ecc_h_nxt;
  logic [NSUB-1:0][ECC_W-1:0]  w_ecc_s_nxt;
  logic [HDR_W-1:0]            w_shadow_h_nxt;
  logic [NSUB-1:0][SUB_W-1:0]  w_shadow_s_nxt;

  logic [HDR_W-1:0]            w_hdr_src;
  logic [NSUB-1:0][SUB_W-1:0]  w_sub_src;
  logic [ECC_W-1:0]            w_ecc_h_cur;
  logic [NSUB-1:0][ECC_W-1:0]  w_ecc_s_cur;
  logic                        w_hdr_bit;
  logic [NSUB-1:0]             w_even;
  logic [NSUB-1:0]             w_odd;

  // Next-slot computation; slot 0 reads the live inputs and restarts parity.
  always_comb begin
    w_cnt_nxt          = '0;
    w_packet_data_nxt  = '0;
    w_slot_nxt         = '0;
    w_packet_start_nxt = 1'b0;
    w_packet_end_nxt   = 1'b0;
    w_ecc_h_nxt        = '0;
    w_ecc_s_nxt        = '0;
    w_shadow_h_nxt     = r_shadow_h;
    w_shadow_s_nxt     = r_shadow_s;
    w_hdr_src          = r_shadow_h;
    w_sub_src          = r_shadow_s;
    w_ecc_h_cur        = r_ecc_h;
    w_ecc_s_cur        = r_ecc_s;
    w_hdr_bit          = 1'b0;
    w_even             = '0;
    w_odd              = '0;

    if (bus.enable) begin
      if (r_cnt == '0) begin
        w_hdr_src      = bus.header;
        w_sub_src      = bus.sub;
        w_ecc_h_cur    = '0;
        w_ecc_s_cur    = '0;
        w_shadow_h_nxt = bus.header;
        w_shadow_s_nxt = bus.sub;
      end

      if (r_cnt < HDR_ECC_SLOT) begin
        w_hdr_bit   = w_hdr_src[r_cnt];
        w_ecc_h_nxt = nx(w_ecc_h_cur, w_hdr_bit);
      end else begin
        w_hdr_bit   = w_ecc_h_cur[r_cnt[2:0]];
        w_ecc_h_nxt = w_ecc_h_cur;
      end

      for (int i = 0; i < NSUB; i++) begin
        if (r_cnt < SUB_ECC_SLOT) begin
          w_even[i]      = w_sub_src[i][{r_cnt, 1'b0}];
          w_odd[i]       = w_sub_src[i][{r_cnt, 1'b1}];
          w_ecc_s_nxt[i] = nx(nx(w_ecc_s_cur[i], w_even[i]), w_odd[i]);
        end else begin
          w_even[i]      = w_ecc_s_cur[i][{r_cnt[1:0], 1'b0}];
          w_odd[i]       = w_ecc_s_cur[i][{r_cnt[1:0], 1'b1}];
          w_ecc_s_nxt[i] = w_ecc_s_cur[i];
        end
      end

      w_packet_data_nxt  = {w_odd, w_even, w_hdr_bit};
      w_slot_nxt         = r_cnt;
      w_packet_start_nxt = (r_cnt == '0);
      w_packet_end_nxt   = (r_cnt == LAST_SLOT);
      w_cnt_nxt          = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt          <= '0;
      r_packet_data  <= '0;
      r_slot         <= '0;
      r_packet_start <= 1'b0;
      r_packet_end   <= 1'b0;
      r_ecc_h        <= '0;
      r_ecc_s        <= '0;
      r_shadow_h     <= '0;
      r_shadow_s     <= '0;
    end else begin
      r_cnt          <= w_cnt_nxt;
      r_packet_data  <= w_packet_data_nxt;
      r_slot         <= w_slot_nxt;
      r_packet_start <= w_packet_start_nxt;
      r_packet_end   <= w_packet_end_nxt;
      r_ecc_h        <= w_ecc_h_nxt;
      r_ecc_s        <= w_ecc_s_nxt;
      r_shadow_h     <= w_shadow_h_nxt;
      r_shadow_s     <= w_shadow_s_nxt;
    end
  end

  assign bus.packet_data  = r_packet_data;
  assign bus.slot         = r_slot;
  assign bus.packet_start = r_packet_start;
  assign bus.packet_end   = r_packet_end;

endmodule

// File: tb/tb_data_island_packet_assembler.sv
// Directed bench for the data-island packet assembler: hand-computed parity
// slots plus a serial reference model for full packets.
module tb_data_island_packet_assembler;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  data_island_packet_assembler_if u_if ();

  data_island_packet_assembler u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] nx(input logic [7:0] e, input logic b);
    return {1'b0, e[7:1]} ^ ({8{e[0] ^ b}} & 8'h83);
  endfunction

  // Reference slot word: parity is recomputed from scratch over the whole field.
  function automatic logic [8:0] model_word(input logic [23:0] h,
                                            input logic [3:0][55:0] s,
                                            input int k);
    logic [8:0]  w;
    logic [7:0]  eh;
    logic [7:0]  es;
    logic [23:0] ht;
    logic [55:0] st;
    w  = '0;
    eh = '0;
    for (int b = 0; b < 24; b++) begin
      ht = h >> b;
      eh = nx(eh, ht[0]);
    end
    if (k < 24) begin
      ht = h >> k;
      w[0] = ht[0];
    end else begin
      es = eh >> (k - 24);
      w[0] = es[0];
    end
    for (int i = 0; i < 4; i++) begin
      es = '0;
      for (int b = 0; b < 56; b++) begin
        st = s[i] >> b;
        es = nx(es, st[0]);
      end
      if (k < 28) begin
        st = s[i] >> (2 * k);
        w[1+i] = st[0];
        w[5+i] = st[1];
      end else begin
        es = es >> (2 * (k - 28));
        w[1+i] = es[0];
        w[5+i] = es[1];
      end
    end
    return w;
  endfunction

  function automatic logic [3:0][55:0] rand_sub();
    logic [3:0][55:0] s;
    for (int i = 0; i < 4; i++) s[i] = 56'({$urandom(), $urandom()});
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    u_if.enable    = 1'b1;
    u_if.header    = 24'hFFFFFF;
    u_if.sub       = '1;
    repeat (3) step();
    n_cmp++;
    if (u_if.packet_data !== 9'h000)
      $display("FAIL reset_pd: got %h want 000", u_if.packet_data);
    n_cmp++;
    if ({u_if.slot, u_if.packet_start, u_if.packet_end} !== 7'h00)
      $display("FAIL reset_ctl: got slot=%0d start=%b end=%b want 0/0/0",
               u_if.slot, u_if.packet_start, u_if.packet_end);
    if (u_if.packet_data !== 9'h000 ||
        {u_if.slot, u_if.packet_start, u_if.packet_end} !== 7'h00) n_err++;
    u_if.enable = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    n_cmp++;
    if ({u_if.packet_data, u_if.slot, u_if.packet_start, u_if.packet_end} !== 16'h0000) begin
      n_err++;
      $display("FAIL idle_after_reset: got pd=%h slot=%0d want 0", u_if.packet_data, u_if.slot);
    end
  endtask

  task automatic test_all_zero();
    u_if.header = '0;
    u_if.sub    = '0;
    u_if.enable = 1'b1;
    for (int k = 0; k < 32; k++) begin
      step();
      if (k == 31) u_if.enable = 1'b0;
      n_cmp++;
      if (u_if.packet_data !== 9'h000) begin
        n_err++;
        $display("FAIL zero_pd slot %0d: got %h want 000", k, u_if.packet_data);
      end
      n_cmp++;
      if (u_if.slot !== 5'(k) || u_if.packet_start !== (k == 0) || u_if.packet_end !== (k == 31)) begin
        n_err++;
        $display("FAIL zero_ctl slot %0d: got slot=%0d start=%b end=%b", k,
                 u_if.slot, u_if.packet_start, u_if.packet_end);
      end
    end
    step();
    n_cmp++;
    if ({u_if.slot, u_if.packet_start, u_if.packet_end} !== 7'h00) begin
      n_err++;
      $display("FAIL zero_idle: got slot=%0d start=%b end=%b want 0/0/0",
               u_if.slot, u_if.packet_start, u_if.packet_end);
    end
  endtask

  task automatic test_header_ecc();
    logic [7:0] exp_ecc;
    logic [7:0] sh;
    logic       want;
    exp_ecc     = 8'h83;
    u_if.header = 24'h800000;
    u_if.sub    = '0;
    u_if.enable = 1'b1;
    for (int k = 0; k < 32; k++) begin
      step();
      if (k == 31) u_if.enable = 1'b0;
      sh   = exp_ecc >> (k - 24);
      want = (k < 23) ? 1'b0 : (k == 23) ? 1'b1 : sh[0];
      n_cmp++;
      if (u_if.packet_data[0] !== want) begin
        n_err++;
        $display("FAIL hdr_ecc slot %0d: got %b want %b", k, u_if.packet_data[0], want);
      end
    end
    step();
  endtask

  task automatic test_sub_ecc();
    logic [3:0][55:0] s;
    logic [1:0]       exp_a [4];
    logic [1:0]       exp_b [4];
    exp_a = '{2'b11, 2'b00, 2'b00, 2'b10};
    exp_b = '{2'b10, 2'b00, 2'b00, 2'b11};

    s = '0;
    s[0][55] = 1'b1;
    u_if.header = '0;
    u_if.sub    = s;
    u_if.enable = 1'b1;
    for (int k = 0; k < 32; k++) begin
      step();
      if (k == 31) u_if.enable = 1'b0;
      if (k == 27) begin
        n_cmp++;
        if (u_if.packet_data[5] !== 1'b1) begin
          n_err++;
          $display("FAIL sub0_bit55 slot 27: got %b want 1", u_if.packet_data[5]);
        end
      end
      if (k >= 28) begin
        n_cmp++;
        if ({u_if.packet_data[5], u_if.packet_data[1]} !== exp_a[k-28]) begin
          n_err++;
          $display("FAIL sub0_ecc slot %0d: got %b want %b", k,
                   {u_if.packet_data[5], u_if.packet_data[1]}, exp_a[k-28]);
        end
      end
    end
    step();

    s = '0;
    s[2][54] = 1'b1;
    u_if.sub    = s;
    u_if.enable = 1'b1;
    for (int k = 0; k < 32; k++) begin
      step();
      if (k == 31) u_if.enable = 1'b0;
      if (k == 27) begin
        n_cmp++;
        if (u_if.packet_data[3] !== 1'b1) begin
          n_err++;
          $display("FAIL sub2_bit54 slot 27: got %b want 1", u_if.packet_data[3]);
        end
      end
      if (k >= 28) begin
        n_cmp++;
        if ({u_if.packet_data[7], u_if.packet_data[3]} !== exp_b[k-28]) begin
          n_err++;
          $display("FAIL sub2_ecc slot %0d: got %b want %b", k,
                   {u_if.packet_data[7], u_if.packet_data[3]}, exp_b[k-28]);
        end
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0][55:0] ss [3];
    logic [8:0]       want;
    for (int p = 0; p < 3; p++) ss[p] = rand_sub();
    u_if.header = 24'h190183;
    u_if.sub    = ss[0];
    u_if.enable = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 32; k++) begin
        step();
        want = model_word(24'h190183, ss[p], k);
        n_cmp++;
        if (u_if.packet_data !== want) begin
          n_err++;
          $display("FAIL b2b_pd pkt %0d slot %0d: got %h want %h", p, k, u_if.packet_data, want);
        end
        n_cmp++;
        if (u_if.slot !== 5'(k) || u_if.packet_start !== (k == 0) || u_if.packet_end !== (k == 31)) begin
          n_err++;
          $display("FAIL b2b_ctl pkt %0d slot %0d: got slot=%0d start=%b end=%b", p, k,
                   u_if.slot, u_if.packet_start, u_if.packet_end);
        end
        if (k == 5) begin
          u_if.header = 24'hE6FE7C;
          u_if.sub    = rand_sub();
        end
        if (k == 31) begin
          if (p < 2) begin
            u_if.header = 24'h190183;
            u_if.sub    = ss[p+1];
          end else begin
            u_if.enable = 1'b0;
          end
        end
      end
    end
    step();
  endtask

  task automatic test_abort();
    logic [3:0][55:0] sa;
    logic [3:0][55:0] sb;
    logic [8:0]       want;
    sa = rand_sub();
    sb = rand_sub();
    u_if.header = 24'h0C0FFE;
    u_if.sub    = sa;
    u_if.enable = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      step();
      want = model_word(24'h0C0FFE, sa, k);
      n_cmp++;
      if (u_if.packet_data !== want || u_if.packet_end !== 1'b0) begin
        n_err++;
        $display("FAIL abort_pre slot %0d: got %h end=%b want %h end=0", k,
                 u_if.packet_data, u_if.packet_end, want);
      end
    end
    u_if.enable = 1'b0;
    u_if.header = 24'h3A5C71;
    u_if.sub    = sb;
    for (int j = 0; j < 3; j++) begin
      step();
      n_cmp++;
      if ({u_if.packet_data, u_if.slot, u_if.packet_start, u_if.packet_end} !== 16'h0000) begin
        n_err++;
        $display("FAIL abort_gap cycle %0d: got pd=%h slot=%0d end=%b want 0", j,
                 u_if.packet_data, u_if.slot, u_if.packet_end);
      end
    end
    u_if.enable = 1'b1;
    for (int k = 0; k < 32; k++) begin
      step();
      if (k == 31) u_if.enable = 1'b0;
      want = model_word(24'h3A5C71, sb, k);
      n_cmp++;
      if (u_if.packet_data !== want || u_if.slot !== 5'(k) || u_if.packet_end !== (k == 31)) begin
        n_err++;
        $display("FAIL abort_restart slot %0d: got pd=%h slot=%0d end=%b want pd=%h", k,
                 u_if.packet_data, u_if.slot, u_if.packet_end, want);
      end
    end
    step();
  endtask

  task automatic test_async_reset();
    logic [3:0][55:0] sc;
    logic [3:0][55:0] sd;
    logic [8:0]       want;
    sc = rand_sub();
    sd = rand_sub();
    u_if.header = 24'h5B2D19;
    u_if.sub    = sc;
    u_if.enable = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      step();
      want = model_word(24'h5B2D19, sc, k);
      n_cmp++;
      if (u_if.packet_data !== want) begin
        n_err++;
        $display("FAIL rst_pre slot %0d: got %h want %h", k, u_if.packet_data, want);
      end
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({u_if.packet_data, u_if.slot, u_if.packet_start, u_if.packet_end} !== 16'h0000) begin
      n_err++;
      $display("FAIL async_reset: got pd=%h slot=%0d start=%b end=%b want 0",
               u_if.packet_data, u_if.slot, u_if.packet_start, u_if.packet_end);
    end
    @(negedge clk);
    u_if.header = 24'h71E4A2;
    u_if.sub    = sd;
    reset_n     = 1'b1;
    for (int k = 0; k < 32; k++) begin
      step();
      if (k == 31) u_if.enable = 1'b0;
      want = model_word(24'h71E4A2, sd, k);
      n_cmp++;
      if (u_if.packet_data !== want || u_if.slot !== 5'(k) || u_if.packet_start !== (k == 0)) begin
        n_err++;
        $display("FAIL rst_restart slot %0d: got pd=%h slot=%0d start=%b want pd=%h", k,
                 u_if.packet_data, u_if.slot, u_if.packet_start, want);
      end
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    u_if.enable = 1'b0;
    u_if.header = '0;
    u_if.sub    = '0;
    test_reset();
    test_all_zero();
    test_header_ecc();
    test_sub_ecc();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
